// File: rtl/add8u_err_pkg.sv
// Shared widths, stage record and arithmetic helpers for the approximate-adder error monitor.
// The optional squared-error path is enabled by defining ADD8U_ERR_MONITOR_MSE_EN.
package add8u_err_pkg;

   localparam int unsigned W         = 8;
   localparam int unsigned CNT_W     = 32;
   localparam int unsigned ACC_W     = 40;
   localparam int unsigned SAT_MAX_W = 64;
   localparam int unsigned ABS_MAX_W = 16;

   typedef struct packed {
      logic         valid;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W:0]   exact;
      logic [W:0]   approx;
   } s1_rec_t;

   // Unsigned magnitude of x - y; callers narrow the result to W+1 bits.
   function automatic logic [ABS_MAX_W-1:0] abs_diff(input logic [ABS_MAX_W-1:0] x,
                                                     input logic [ABS_MAX_W-1:0] y);
      return (x >= y) ? (x - y) : (y - x);
   endfunction

   // Saturating add clamped to 'width' bits; returns {hit, value}.
   function automatic logic [SAT_MAX_W:0] sat_add(input logic [SAT_MAX_W-1:0] acc,
                                                  input logic [SAT_MAX_W-1:0] inc,
                                                  input int unsigned          width);
      logic [SAT_MAX_W:0] sum;
      logic [SAT_MAX_W:0] lim;
      sum = {1'b0, acc} + {1'b0, inc};
      lim = ((SAT_MAX_W+1)'(1) << width) - (SAT_MAX_W+1)'(1);
      if (sum > lim) begin
         return {1'b1, lim[SAT_MAX_W-1:0]};
      end
      return {1'b0, sum[SAT_MAX_W-1:0]};
   endfunction

endpackage

// File: rtl/add8u_err_accum.sv
// Statistics register bank: saturating counters, absolute-error sum and first-occurrence WCE.
// Squared-error accumulator present only when ADD8U_ERR_MONITOR_MSE_EN is defined.
module add8u_err_accum #(
   parameter int unsigned W     = add8u_err_pkg::W,
   parameter int unsigned CNT_W = add8u_err_pkg::CNT_W,
   parameter int unsigned ACC_W = add8u_err_pkg::ACC_W
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_clear,
   input  logic               i_valid,
   input  logic [W:0]         i_d,
   input  logic [W-1:0]       i_a,
   input  logic [W-1:0]       i_b,
`ifdef ADD8U_ERR_MONITOR_MSE_EN
   input  logic [2*W+1:0]     i_sq,
   output logic [ACC_W+W+1:0] o_sq_err_sum,
`endif
   output logic [CNT_W-1:0]   o_sample_cnt,
   output logic [CNT_W-1:0]   o_err_cnt,
   output logic [ACC_W-1:0]   o_abs_err_sum,
   output logic [W:0]         o_wce,
   output logic [W-1:0]       o_wce_a,
   output logic [W-1:0]       o_wce_b,
   output logic               o_sat_hit_c
);
   import add8u_err_pkg::*;

   localparam int unsigned SQ_W = ACC_W + W + 2;

   logic [CNT_W-1:0]   r_sample_cnt;
   logic [CNT_W-1:0]   r_err_cnt;
   logic [ACC_W-1:0]   r_abs_err_sum;
   logic [W:0]         r_wce;
   logic [W-1:0]       r_wce_a;
   logic [W-1:0]       r_wce_b;

   logic [SAT_MAX_W:0] w_smp_add;
   logic [SAT_MAX_W:0] w_err_add;
   logic [SAT_MAX_W:0] w_abs_add;
   logic               w_new_wce;
   logic               w_unused_hi;

`ifdef ADD8U_ERR_MONITOR_MSE_EN
   logic [SQ_W-1:0]    r_sq_err_sum;
   logic [SAT_MAX_W:0] w_sq_add;
   logic               w_unused_sq;

   always_comb begin
      w_sq_add    = sat_add(SAT_MAX_W'(r_sq_err_sum), SAT_MAX_W'(i_sq), SQ_W);
      w_unused_sq = ^w_sq_add[SAT_MAX_W-1:SQ_W];
   end
`endif

   // Candidate next values; an overflowing field clamps at all-ones and flags a hit.
   always_comb begin
      w_smp_add   = sat_add(SAT_MAX_W'(r_sample_cnt), SAT_MAX_W'(1), CNT_W);
      w_err_add   = sat_add(SAT_MAX_W'(r_err_cnt), SAT_MAX_W'(i_d != '0), CNT_W);
      w_abs_add   = sat_add(SAT_MAX_W'(r_abs_err_sum), SAT_MAX_W'(i_d), ACC_W);
      w_new_wce   = (i_d > r_wce);
      w_unused_hi = ^{w_smp_add[SAT_MAX_W-1:CNT_W], w_err_add[SAT_MAX_W-1:CNT_W],
                      w_abs_add[SAT_MAX_W-1:ACC_W]};
      o_sat_hit_c = i_valid & (w_smp_add[SAT_MAX_W] | w_err_add[SAT_MAX_W] |
                               w_abs_add[SAT_MAX_W]
`ifdef ADD8U_ERR_MONITOR_MSE_EN
                               | w_sq_add[SAT_MAX_W]
`endif
                              );
   end

   // Clear wins over a same-cycle update.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sample_cnt  <= '0;
         r_err_cnt     <= '0;
         r_abs_err_sum <= '0;
         r_wce         <= '0;
         r_wce_a       <= '0;
         r_wce_b       <= '0;
      end else if (i_clear) begin
         r_sample_cnt  <= '0;
         r_err_cnt     <= '0;
         r_abs_err_sum <= '0;
         r_wce         <= '0;
         r_wce_a       <= '0;
         r_wce_b       <= '0;
      end else if (i_valid) begin
         r_sample_cnt  <= CNT_W'(w_smp_add[SAT_MAX_W-1:0]);
         r_err_cnt     <= CNT_W'(w_err_add[SAT_MAX_W-1:0]);
         r_abs_err_sum <= ACC_W'(w_abs_add[SAT_MAX_W-1:0]);
         if (w_new_wce) begin
            r_wce   <= i_d;
            r_wce_a <= i_a;
            r_wce_b <= i_b;
         end
      end
   end

`ifdef ADD8U_ERR_MONITOR_MSE_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sq_err_sum <= '0;
      end else if (i_clear) begin
         r_sq_err_sum <= '0;
      end else if (i_valid) begin
         r_sq_err_sum <= SQ_W'(w_sq_add[SAT_MAX_W-1:0]);
      end
   end

   assign o_sq_err_sum = r_sq_err_sum;
`endif

   assign o_sample_cnt  = r_sample_cnt;
   assign o_err_cnt     = r_err_cnt;
   assign o_abs_err_sum = r_abs_err_sum;
   assign o_wce         = r_wce;
   assign o_wce_a       = r_wce_a;
   assign o_wce_b       = r_wce_b;

endmodule

// File: rtl/add8u_err_monitor.sv
// Streaming error monitor for an 8-bit approximate adder: handshake, exact-sum stage, clear/sat control.
// ADD8U_ERR_MONITOR_MSE_EN adds a registered d*d stage and the sq_err_sum output.
module add8u_err_monitor #(
   parameter int unsigned W     = add8u_err_pkg::W,
   parameter int unsigned CNT_W = add8u_err_pkg::CNT_W,
   parameter int unsigned ACC_W = add8u_err_pkg::ACC_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       in_a,
   input  logic [W-1:0]       in_b,
   input  logic [W:0]         in_approx,
   output logic [CNT_W-1:0]   sample_cnt,
   output logic [CNT_W-1:0]   err_cnt,
   output logic [ACC_W-1:0]   abs_err_sum,
`ifdef ADD8U_ERR_MONITOR_MSE_EN
   output logic [ACC_W+W+1:0] sq_err_sum,
`endif
   output logic [W:0]         wce,
   output logic [W-1:0]       wce_a,
   output logic [W-1:0]       wce_b,
   output logic               busy,
   output logic               sat
);
   import add8u_err_pkg::*;

   s1_rec_t      r_s1;
   logic         r_s2_valid;
   logic [W:0]   r_s2_d;
   logic [W-1:0] r_s2_a;
   logic [W-1:0] r_s2_b;
   logic         r_sat;

   logic         w_accept;
   logic [W:0]   w_exact;
   logic [W:0]   w_s1_d;
   logic         w_acc_valid;
   logic [W:0]   w_acc_d;
   logic [W-1:0] w_acc_a;
   logic [W-1:0] w_acc_b;
   logic         w_sat_hit;

   assign in_ready = ~clear & ~r_sat;
   assign w_accept = in_valid & in_ready;
   assign w_exact  = (W+1)'(in_a) + (W+1)'(in_b);
   assign w_s1_d   = (W+1)'(abs_diff(ABS_MAX_W'(r_s1.approx), ABS_MAX_W'(r_s1.exact)));

   // S1: capture operands with the exact W+1-bit sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= '0;
      end else if (clear) begin
         r_s1 <= '0;
      end else begin
         r_s1.valid <= w_accept;
         if (w_accept) begin
            r_s1.a      <= in_a;
            r_s1.b      <= in_b;
            r_s1.exact  <= w_exact;
            r_s1.approx <= in_approx;
         end
      end
   end

   // S2: error magnitude ready for the statistics bank.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_d     <= '0;
         r_s2_a     <= '0;
         r_s2_b     <= '0;
      end else if (clear) begin
         r_s2_valid <= 1'b0;
         r_s2_d     <= '0;
         r_s2_a     <= '0;
         r_s2_b     <= '0;
      end else begin
         r_s2_valid <= r_s1.valid;
         if (r_s1.valid) begin
            r_s2_d <= w_s1_d;
            r_s2_a <= r_s1.a;
            r_s2_b <= r_s1.b;
         end
      end
   end

`ifdef ADD8U_ERR_MONITOR_MSE_EN
   logic           r_s3_valid;
   logic [W:0]     r_s3_d;
   logic [2*W+1:0] r_s3_sq;
   logic [W-1:0]   r_s3_a;
   logic [W-1:0]   r_s3_b;
   logic [2*W+1:0] w_s2_sq;

   assign w_s2_sq = (2*W+2)'(r_s2_d) * (2*W+2)'(r_s2_d);

   // S3: registered square so the multiplier does not share a cycle with the adders.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s3_valid <= 1'b0;
         r_s3_d     <= '0;
         r_s3_sq    <= '0;
         r_s3_a     <= '0;
         r_s3_b     <= '0;
      end else if (clear) begin
         r_s3_valid <= 1'b0;
         r_s3_d     <= '0;
         r_s3_sq    <= '0;
         r_s3_a     <= '0;
         r_s3_b     <= '0;
      end else begin
         r_s3_valid <= r_s2_valid;
         if (r_s2_valid) begin
            r_s3_d  <= r_s2_d;
            r_s3_sq <= w_s2_sq;
            r_s3_a  <= r_s2_a;
            r_s3_b  <= r_s2_b;
         end
      end
   end

   assign w_acc_valid = r_s3_valid;
   assign w_acc_d     = r_s3_d;
   assign w_acc_a     = r_s3_a;
   assign w_acc_b     = r_s3_b;
   assign busy        = r_s1.valid | r_s2_valid | r_s3_valid;
`else
   assign w_acc_valid = r_s2_valid;
   assign w_acc_d     = r_s2_d;
   assign w_acc_a     = r_s2_a;
   assign w_acc_b     = r_s2_b;
   assign busy        = r_s1.valid | r_s2_valid;
`endif

   add8u_err_accum #(
      .W     (W),
      .CNT_W (CNT_W),
      .ACC_W (ACC_W)
   ) u_accum (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_clear       (clear),
      .i_valid       (w_acc_valid),
      .i_d           (w_acc_d),
      .i_a           (w_acc_a),
      .i_b           (w_acc_b),
`ifdef ADD8U_ERR_MONITOR_MSE_EN
      .i_sq          (r_s3_sq),
      .o_sq_err_sum  (sq_err_sum),
`endif
      .o_sample_cnt  (sample_cnt),
      .o_err_cnt     (err_cnt),
      .o_abs_err_sum (abs_err_sum),
      .o_wce         (wce),
      .o_wce_a       (wce_a),
      .o_wce_b       (wce_b),
      .o_sat_hit_c   (w_sat_hit)
   );

   // Sticky saturation flag; only clear or reset drops it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sat <= 1'b0;
      end else if (clear) begin
         r_sat <= 1'b0;
      end else if (w_sat_hit) begin
         r_sat <= 1'b1;
      end
   end

   assign sat = r_sat;

endmodule

// File: tb/tb_add8u_err_monitor.sv
// Directed bench for add8u_err_monitor: a default-width instance plus a CNT_W=4 instance for saturation.
module tb_add8u_err_monitor;

   localparam int unsigned W      = 8;
   localparam int unsigned CNT_W  = 32;
   localparam int unsigned ACC_W  = 40;
   localparam int unsigned CNT4_W = 4;
`ifdef ADD8U_ERR_MONITOR_MSE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clear = 1'b0;
   logic in_valid = 1'b0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic [W:0]   in_approx = '0;

   logic               in_ready, busy, sat;
   logic [CNT_W-1:0]   sample_cnt, err_cnt;
   logic [ACC_W-1:0]   abs_err_sum;
   logic [W:0]         wce;
   logic [W-1:0]       wce_a, wce_b;

   logic               in_ready4, busy4, sat4;
   logic [CNT4_W-1:0]  sample_cnt4, err_cnt4;
   logic [ACC_W-1:0]   abs_err_sum4;
   logic [W:0]         wce4;
   logic [W-1:0]       wce_a4, wce_b4;
`ifdef ADD8U_ERR_MONITOR_MSE_EN
   logic [ACC_W+W+1:0] sq_err_sum, sq_err_sum4;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] t3_a [3] = '{8'd10, 8'd100, 8'd3};
   logic [7:0] t3_b [3] = '{8'd20, 8'd100, 8'd4};
   logic [8:0] t3_s [3] = '{9'd35, 9'd124, 9'd83};

   add8u_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_approx   (in_approx),
      .sample_cnt  (sample_cnt),
      .err_cnt     (err_cnt),
      .abs_err_sum (abs_err_sum),
`ifdef ADD8U_ERR_MONITOR_MSE_EN
      .sq_err_sum  (sq_err_sum),
`endif
      .wce         (wce),
      .wce_a       (wce_a),
      .wce_b       (wce_b),
      .busy        (busy),
      .sat         (sat)
   );

   add8u_err_monitor #(.W(W), .CNT_W(CNT4_W), .ACC_W(ACC_W)) dut4 (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_ready    (in_ready4),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_approx   (in_approx),
      .sample_cnt  (sample_cnt4),
      .err_cnt     (err_cnt4),
      .abs_err_sum (abs_err_sum4),
`ifdef ADD8U_ERR_MONITOR_MSE_EN
      .sq_err_sum  (sq_err_sum4),
`endif
      .wce         (wce4),
      .wce_a       (wce_a4),
      .wce_b       (wce_b4),
      .busy        (busy4),
      .sat         (sat4)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present one sample at a negedge; it is taken on the following posedge.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] s);
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_approx = s;
      @(negedge clk);
      in_valid  = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_pulse();
      clear = 1'b1;
      #1 check("clr_ready_low", 64'(in_ready), 64'd0);
      @(negedge clk);
      clear = 1'b0;
      #1 check("clr_ready_back", 64'(in_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_cnt",  64'(sample_cnt),  64'd0);
      check("rst_err",  64'(err_cnt),     64'd0);
      check("rst_abs",  64'(abs_err_sum), 64'd0);
      check("rst_wce",  64'(wce),         64'd0);
      check("rst_busy", 64'(busy),        64'd0);
      check("rst_sat",  64'(sat),         64'd0);
      rst = 1'b0;
      #1 check("rst_ready", 64'(in_ready), 64'd1);
      @(negedge clk);

      // Single erroneous sample and its latency.
      send(8'd100, 8'd50, 9'd140);
      idle(1);
      check("t1_early_cnt", 64'(sample_cnt), 64'd0);
      check("t1_busy",      64'(busy),       64'd1);
      idle(LAT - 1);
      check("t1_cnt",   64'(sample_cnt),  64'd1);
      check("t1_err",   64'(err_cnt),     64'd1);
      check("t1_abs",   64'(abs_err_sum), 64'd10);
      check("t1_wce",   64'(wce),         64'd10);
      check("t1_wce_a", 64'(wce_a),       64'd100);
      check("t1_wce_b", 64'(wce_b),       64'd50);
      check("t1_idle",  64'(busy),        64'd0);
`ifdef ADD8U_ERR_MONITOR_MSE_EN
      check("t1_sq",    64'(sq_err_sum),  64'd100);
`endif

      // Full-range exact sample: 255+255 = 510 must not truncate.
      send(8'd255, 8'd255, 9'd510);
      idle(LAT);
      check("t2_cnt", 64'(sample_cnt),  64'd2);
      check("t2_err", 64'(err_cnt),     64'd1);
      check("t2_abs", 64'(abs_err_sum), 64'd10);
      check("t2_wce", 64'(wce),         64'd10);

      // Back-to-back d=5, 76, 76: first 76 keeps its operands.
      clear_pulse();
      for (int i = 0; i < 3; i++) begin
         #1 check("t3_ready", 64'(in_ready), 64'd1);
         send(t3_a[i], t3_b[i], t3_s[i]);
      end
      idle(LAT);
      check("t3_cnt",   64'(sample_cnt),  64'd3);
      check("t3_err",   64'(err_cnt),     64'd3);
      check("t3_abs",   64'(abs_err_sum), 64'd157);
      check("t3_wce",   64'(wce),         64'd76);
      check("t3_wce_a", 64'(wce_a),       64'd100);
      check("t3_wce_b", 64'(wce_b),       64'd100);
      check("t3_ready_end", 64'(in_ready), 64'd1);

      // Clear with two samples in flight and a third presented during clear.
      send(8'd20, 8'd20, 9'd60);
      send(8'd1, 8'd2, 9'd3);
      clear     = 1'b1;
      in_valid  = 1'b1;
      in_a      = 8'd9;
      in_b      = 8'd9;
      in_approx = 9'd0;
      #1 check("t4_ready", 64'(in_ready), 64'd0);
      check("t4_busy_pre", 64'(busy), 64'd1);
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      check("t4_cnt",   64'(sample_cnt),  64'd0);
      check("t4_err",   64'(err_cnt),     64'd0);
      check("t4_abs",   64'(abs_err_sum), 64'd0);
      check("t4_wce",   64'(wce),         64'd0);
      check("t4_wce_a", 64'(wce_a),       64'd0);
      check("t4_busy",  64'(busy),        64'd0);
      check("t4_sat",   64'(sat),         64'd0);
      idle(4);
      check("t4_late_cnt",  64'(sample_cnt), 64'd0);
      check("t4_late_busy", 64'(busy),       64'd0);

      // Saturation on the 4-bit-counter instance: 16 samples with d=1.
      for (int i = 0; i < 16; i++) begin
         #1 check("t5_ready4", 64'(in_ready4), 64'd1);
         send(8'd1, 8'd1, 9'd3);
      end
      idle(LAT);
      check("t5_cnt4",   64'(sample_cnt4),  64'd15);
      check("t5_err4",   64'(err_cnt4),     64'd15);
      check("t5_abs4",   64'(abs_err_sum4), 64'd16);
      check("t5_sat4",   64'(sat4),         64'd1);
      check("t5_rdy4",   64'(in_ready4),    64'd0);
      check("t5_cnt",    64'(sample_cnt),   64'd16);
      check("t5_sat",    64'(sat),          64'd0);
      idle(2);
      check("t5_sticky", 64'(sat4),         64'd1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      #1;
      check("t5_clr_sat4", 64'(sat4),        64'd0);
      check("t5_clr_rdy4", 64'(in_ready4),   64'd1);
      check("t5_clr_cnt4", 64'(sample_cnt4), 64'd0);
      @(negedge clk);

      // Maximum error then asynchronous reset with a sample in flight.
      send(8'd0, 8'd0, 9'd511);
      idle(LAT);
      check("t6_wce",   64'(wce),         64'd511);
      check("t6_wce_a", 64'(wce_a),       64'd0);
      check("t6_abs",   64'(abs_err_sum), 64'd511);
      send(8'd7, 8'd7, 9'd0);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_cnt",  64'(sample_cnt),  64'd0);
      check("t6_rst_abs",  64'(abs_err_sum), 64'd0);
      check("t6_rst_wce",  64'(wce),         64'd0);
      check("t6_rst_busy", 64'(busy),        64'd0);
      @(negedge clk);
      rst = 1'b0;
      idle(LAT + 1);
      check("t6_post_cnt",  64'(sample_cnt), 64'd0);
      check("t6_post_busy", 64'(busy),       64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
